// File: rtl/spi_bus_arbiter.sv
// spi_bus_arbiter: round-robin sharing of one SPI pin group with chip-select setup, hold and gap timing.
// Define SPI_BUS_ARBITER_TIMEOUT_EN to add the ownership watchdog and per-requester lockout.
module spi_bus_arbiter #(
   parameter int unsigned  NumReq        = 3,
   parameter int unsigned  CsSetupCycles = 2,
   parameter int unsigned  CsHoldCycles  = 2,
   parameter int unsigned  GapCycles     = 1,
   parameter logic         Cpol          = 1'b0,
   parameter int unsigned  TimeoutCycles = 4096,
   localparam int unsigned OwnerW        = $clog2(NumReq)
) (
   input  logic              clk_sys_i,
   input  logic              rst_sys_ni,
   input  logic [NumReq-1:0] req_i,
   output logic [NumReq-1:0] gnt_o,
   input  logic [NumReq-1:0] sclk_i,
   input  logic [NumReq-1:0] copi_i,
   output logic [NumReq-1:0] cipo_o,
   output logic              spi_sclk_o,
   output logic              spi_copi_o,
   output logic              spi_copi_en_o,
   output logic [NumReq-1:0] spi_cs_no,
   input  logic              spi_cipo_i,
   output logic              busy_o,
   output logic [OwnerW-1:0] owner_o,
   output logic              timeout_o
);

   function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
      return (a > b) ? a : b;
   endfunction

   function automatic logic [NumReq-1:0] onehot(input logic [OwnerW-1:0] idx);
      return {{(NumReq-1){1'b0}}, 1'b1} << idx;
   endfunction

   localparam int unsigned CntMax = max_u(max_u(CsSetupCycles, CsHoldCycles),
                                          max_u(GapCycles, TimeoutCycles));
   localparam int unsigned CntW   = $clog2(CntMax) + 1;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_SETUP = 3'd1,
      ST_OWN   = 3'd2,
      ST_HOLD  = 3'd3,
      ST_GAP   = 3'd4
   } state_e;

   state_e            state_r, state_s;
   logic [OwnerW-1:0] owner_r, owner_s, last_r, last_s, pick_idx_s, idx_s;
   logic [NumReq-1:0] gnt_r, gnt_s, cs_r, cs_s, elig_s;
   logic [CntW-1:0]   cnt_r;
   logic              busy_r, pick_valid_s, hit_s, own_s;

`ifdef SPI_BUS_ARBITER_TIMEOUT_EN
   logic [NumReq-1:0] lock_r, lock_set_s;
   logic              timeout_r, timeout_s;

   // A revoked requester stays ineligible until it drops its request.
   assign elig_s    = req_i & ~lock_r;
   assign timeout_o = timeout_r;
`else
   assign elig_s    = req_i;
   assign timeout_o = 1'b0;
`endif

   // Round-robin search upward from the last owner, wrapping modulo NumReq.
   always_comb begin
      pick_valid_s = 1'b0;
      pick_idx_s   = {OwnerW{1'b0}};
      idx_s        = {OwnerW{1'b0}};
      hit_s        = 1'b0;
      for (int unsigned off = 32'd1; off <= NumReq; off++) begin
         idx_s        = OwnerW'((32'(last_r) + off) % NumReq);
         hit_s        = elig_s[idx_s];
         pick_idx_s   = (hit_s && !pick_valid_s) ? idx_s : pick_idx_s;
         pick_valid_s = pick_valid_s | hit_s;
      end
   end

   // Next-state, grant and chip-select decisions.
   always_comb begin
      state_s = state_r;
      owner_s = owner_r;
      last_s  = last_r;
      gnt_s   = gnt_r;
      cs_s    = cs_r;
`ifdef SPI_BUS_ARBITER_TIMEOUT_EN
      timeout_s  = 1'b0;
      lock_set_s = {NumReq{1'b0}};
`endif
      case (state_r)
         ST_IDLE: begin
            if (pick_valid_s) begin
               state_s = ST_SETUP;
               owner_s = pick_idx_s;
               last_s  = pick_idx_s;
               cs_s    = ~onehot(pick_idx_s);
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_SETUP: begin
            // A request withdrawn during setup still honours the CS hold time.
            if (!req_i[owner_r]) begin
               state_s = ST_HOLD;
            end else if (cnt_r == CntW'(CsSetupCycles - 32'd1)) begin
               state_s = ST_OWN;
               gnt_s   = onehot(owner_r);
            end else begin
               state_s = ST_SETUP;
            end
         end
         ST_OWN: begin
            if (!req_i[owner_r]) begin
               state_s = ST_HOLD;
               gnt_s   = {NumReq{1'b0}};
`ifdef SPI_BUS_ARBITER_TIMEOUT_EN
            end else if (cnt_r == CntW'(TimeoutCycles - 32'd1)) begin
               state_s    = ST_HOLD;
               gnt_s      = {NumReq{1'b0}};
               timeout_s  = 1'b1;
               lock_set_s = onehot(owner_r);
`endif
            end else begin
               state_s = ST_OWN;
            end
         end
         ST_HOLD: begin
            if (cnt_r == CntW'(CsHoldCycles - 32'd1)) begin
               state_s = ST_GAP;
               cs_s    = {NumReq{1'b1}};
            end else begin
               state_s = ST_HOLD;
            end
         end
         ST_GAP: begin
            if (cnt_r == CntW'(GapCycles - 32'd1)) begin
               state_s = ST_IDLE;
            end else begin
               state_s = ST_GAP;
            end
         end
         default: begin
            state_s = ST_IDLE;
            gnt_s   = {NumReq{1'b0}};
            cs_s    = {NumReq{1'b1}};
         end
      endcase
   end

   // State, ownership and registered pin-facing outputs.
   always_ff @(posedge clk_sys_i or negedge rst_sys_ni) begin
      if (!rst_sys_ni) begin
         state_r <= ST_IDLE;
         owner_r <= {OwnerW{1'b0}};
         last_r  <= OwnerW'(NumReq - 32'd1);
         gnt_r   <= {NumReq{1'b0}};
         cs_r    <= {NumReq{1'b1}};
         busy_r  <= 1'b0;
      end else begin
         state_r <= state_s;
         owner_r <= owner_s;
         last_r  <= last_s;
         gnt_r   <= gnt_s;
         cs_r    <= cs_s;
         busy_r  <= (state_s != ST_IDLE);
      end
   end

   // Phase counter restarts on every state entry and rests at zero in IDLE.
   always_ff @(posedge clk_sys_i or negedge rst_sys_ni) begin
      if (!rst_sys_ni) begin
         cnt_r <= {CntW{1'b0}};
      end else if ((state_s != state_r) || (state_r == ST_IDLE)) begin
         cnt_r <= {CntW{1'b0}};
      end else begin
         cnt_r <= cnt_r + {{(CntW-1){1'b0}}, 1'b1};
      end
   end

`ifdef SPI_BUS_ARBITER_TIMEOUT_EN
   // Watchdog pulse and lockout bits, cleared whenever the request is low.
   always_ff @(posedge clk_sys_i or negedge rst_sys_ni) begin
      if (!rst_sys_ni) begin
         timeout_r <= 1'b0;
         lock_r    <= {NumReq{1'b0}};
      end else begin
         timeout_r <= timeout_s;
         lock_r    <= (lock_r | lock_set_s) & req_i;
      end
   end
`endif

   assign own_s         = |gnt_r;
   assign gnt_o         = gnt_r;
   assign spi_cs_no     = cs_r;
   assign busy_o        = busy_r;
   assign owner_o       = owner_r;
   assign spi_sclk_o    = own_s ? sclk_i[owner_r] : Cpol;
   assign spi_copi_o    = own_s ? copi_i[owner_r] : 1'b0;
   assign spi_copi_en_o = own_s;
   assign cipo_o        = gnt_r & {NumReq{spi_cipo_i}};

endmodule

// File: tb/tb_spi_bus_arbiter.sv
// Bench for spi_bus_arbiter: directed scenarios plus random requests, every cycle compared
// against a transaction-phase reference model with countdown timers.
module tb_spi_bus_arbiter;
   localparam int   N     = 3;
   localparam int   SETUP = 2;
   localparam int   HOLD  = 2;
   localparam int   GAP   = 1;
   localparam int   TMO   = 16;
   localparam logic CPOL  = 1'b0;

   localparam int P_IDLE = 0, P_SETUP = 1, P_OWN = 2, P_HOLD = 3, P_GAP = 4;

   logic         clk = 1'b0;
   logic         rst_n;
   logic [N-1:0] req_i, gnt_o, sclk_i, copi_i, cipo_o, spi_cs_no;
   logic         spi_sclk_o, spi_copi_o, spi_copi_en_o, spi_cipo_i, busy_o, timeout_o;
   logic [1:0]   owner_o;

   int n_cmp = 0;
   int n_bad = 0;

   int           m_phase, m_left, m_owner, m_last, m_own_cycles;
   logic [N-1:0] m_lock;
   logic         m_to;

   spi_bus_arbiter #(
      .NumReq(N), .CsSetupCycles(SETUP), .CsHoldCycles(HOLD), .GapCycles(GAP),
      .Cpol(CPOL), .TimeoutCycles(TMO)
   ) dut (
      .clk_sys_i(clk), .rst_sys_ni(rst_n), .req_i(req_i), .gnt_o(gnt_o),
      .sclk_i(sclk_i), .copi_i(copi_i), .cipo_o(cipo_o), .spi_sclk_o(spi_sclk_o),
      .spi_copi_o(spi_copi_o), .spi_copi_en_o(spi_copi_en_o), .spi_cs_no(spi_cs_no),
      .spi_cipo_i(spi_cipo_i), .busy_o(busy_o), .owner_o(owner_o), .timeout_o(timeout_o)
   );

   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "time limit");
   end

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_phase = P_IDLE; m_left = 0; m_owner = 0; m_last = N - 1;
      m_own_cycles = 0; m_lock = '0; m_to = 1'b0;
   endtask

   // Advance the reference model by one clock edge using the sampled requests.
   task automatic model_edge();
      logic [N-1:0] r;
      r = req_i;
      m_to = 1'b0;
      case (m_phase)
         P_IDLE: begin
            for (int k = 1; k <= N; k++) begin
               int c;
               c = (m_last + k) % N;
               if (r[c] && !m_lock[c]) begin
                  m_owner = c; m_last = c; m_phase = P_SETUP; m_left = SETUP;
                  break;
               end
            end
         end
         P_SETUP: begin
            if (!r[m_owner]) begin
               m_phase = P_HOLD; m_left = HOLD;
            end else begin
               m_left--;
               if (m_left == 0) begin m_phase = P_OWN; m_own_cycles = 0; end
            end
         end
         P_OWN: begin
            if (!r[m_owner]) begin
               m_phase = P_HOLD; m_left = HOLD;
            end else begin
               m_own_cycles++;
`ifdef SPI_BUS_ARBITER_TIMEOUT_EN
               if (m_own_cycles == TMO) begin
                  m_phase = P_HOLD; m_left = HOLD; m_to = 1'b1; m_lock[m_owner] = 1'b1;
               end
`endif
            end
         end
         P_HOLD: begin
            m_left--;
            if (m_left == 0) begin m_phase = P_GAP; m_left = GAP; end
         end
         default: begin
            m_left--;
            if (m_left == 0) m_phase = P_IDLE;
         end
      endcase
`ifdef SPI_BUS_ARBITER_TIMEOUT_EN
      m_lock = m_lock & r;
`endif
   endtask

   task automatic compare_all();
      logic [N-1:0] oh, exp_cs, exp_gnt;
      logic         in_cs, own;
      oh      = {{(N-1){1'b0}}, 1'b1} << m_owner;
      in_cs   = (m_phase == P_SETUP) || (m_phase == P_OWN) || (m_phase == P_HOLD);
      own     = (m_phase == P_OWN);
      exp_cs  = in_cs ? ~oh : {N{1'b1}};
      exp_gnt = own ? oh : '0;
      check_val("cs", spi_cs_no, exp_cs);
      check_val("gnt", gnt_o, exp_gnt);
      check_val("busy", busy_o, m_phase != P_IDLE);
      if (m_phase != P_IDLE) check_val("owner", owner_o, m_owner);
      check_val("sclk", spi_sclk_o, own ? sclk_i[m_owner] : CPOL);
      check_val("copi", spi_copi_o, own ? copi_i[m_owner] : 1'b0);
      check_val("copi_en", spi_copi_en_o, own);
      check_val("cipo", cipo_o, spi_cipo_i ? exp_gnt : '0);
      check_val("timeout", timeout_o, m_to);
      check_val("cs_excl", $countones(~spi_cs_no) <= 1, 1);
   endtask

   task automatic tick();
      @(posedge clk);
      model_edge();
      #1;
      compare_all();
      @(negedge clk);
   endtask

   task automatic do_reset();
      req_i = '0; sclk_i = '0; copi_i = '0; spi_cipo_i = 1'b0;
      rst_n = 1'b0;
      model_reset();
      repeat (2) @(negedge clk);
      check_val("rst_cs", spi_cs_no, 3'b111);
      check_val("rst_gnt", gnt_o, 3'b000);
      check_val("rst_busy", busy_o, 1'b0);
      check_val("rst_owner", owner_o, 2'd0);
      check_val("rst_timeout", timeout_o, 1'b0);
      check_val("rst_sclk", spi_sclk_o, CPOL);
      rst_n = 1'b1;
   endtask

   task automatic wait_idle(input string tag);
      int t;
      t = 0;
      while (m_phase != P_IDLE && t < 20) begin tick(); t++; end
      if (m_phase != P_IDLE) check_val(tag, m_phase, P_IDLE);
   endtask

   initial begin
      int owners[$];
      int t, own_cnt, cs_low, gnt_seen, gcount;
      logic prev_busy;

      // Single transaction latency, pass-through and release timing.
      do_reset();
      req_i = 3'b001;
      tick(); check_val("t1_cs_c1", spi_cs_no, 3'b110);
      tick(); check_val("t1_gnt_c2", gnt_o, 3'b000);
      tick(); check_val("t1_gnt_c3", gnt_o, 3'b001);
      sclk_i = 3'b001; #1 check_val("t1_sclk", spi_sclk_o, 1'b1);
      spi_cipo_i = 1'b1; #1 check_val("t1_cipo", cipo_o, 3'b001);
      req_i = 3'b000;
      tick(); check_val("t2_gnt", gnt_o, 3'b000); check_val("t2_cs1", spi_cs_no, 3'b110);
      tick(); check_val("t2_cs2", spi_cs_no, 3'b110);
      tick(); check_val("t2_gap", spi_cs_no, 3'b111); check_val("t2_gapbusy", busy_o, 1'b1);
      tick(); check_val("t2_idle", busy_o, 1'b0);

      // Round-robin with all requesters persistent; each owner releases after 3 OWN cycles.
      do_reset();
      req_i = 3'b111; prev_busy = 1'b0; own_cnt = 0; t = 0;
      while (owners.size() < 4 && t < 200) begin
         tick(); t++;
         if (busy_o && !prev_busy) owners.push_back(int'(owner_o));
         prev_busy = busy_o;
         own_cnt   = (m_phase == P_OWN) ? own_cnt + 1 : 0;
         req_i     = (own_cnt == 3) ? (3'b111 & ~(3'b001 << m_owner)) : 3'b111;
      end
      check_val("rr_count", owners.size(), 4);
      foreach (owners[i]) check_val("rr_owner", owners[i], i % N);
      req_i = '0;
      wait_idle("rr_drain");

      // Request withdrawn during setup: CS1 low for 1+HOLD cycles, never granted.
      req_i = 3'b010;
      cs_low = 0; gnt_seen = 0;
      for (int i = 0; i < 8; i++) begin
         tick();
         req_i = '0;
         if (!spi_cs_no[1]) cs_low++;
         if (gnt_o != '0) gnt_seen++;
      end
      check_val("abort_cs_low", cs_low, 1 + HOLD);
      check_val("abort_gnt", gnt_seen, 0);
      check_val("abort_idle", busy_o, 1'b0);

      // Asynchronous reset while owning the bus.
      req_i = 3'b001; t = 0;
      while (m_phase != P_OWN && t < 20) begin tick(); t++; end
      check_val("rst_own_reached", gnt_o, 3'b001);
      sclk_i = 3'b001;
      #2 rst_n = 1'b0;
      #1;
      check_val("arst_cs", spi_cs_no, 3'b111);
      check_val("arst_gnt", gnt_o, 3'b000);
      check_val("arst_sclk", spi_sclk_o, CPOL);
      do_reset();

`ifdef SPI_BUS_ARBITER_TIMEOUT_EN
      // Watchdog revokes requester 2, grants pending requester 0, then locks 2 out.
      req_i = 3'b100; t = 0;
      while (m_phase != P_OWN && t < 20) begin tick(); t++; end
      gcount = 0; t = 0;
      while (!timeout_o && t < 40) begin
         if (gnt_o == 3'b100) gcount++;
         req_i = 3'b101;
         tick(); t++;
      end
      check_val("to_pulse", timeout_o, 1'b1);
      check_val("to_own_cycles", gcount, TMO);
      t = 0;
      while (gnt_o == '0 && t < 20) begin tick(); t++; end
      check_val("to_next_gnt", gnt_o, 3'b001);
      req_i = 3'b100;
      gnt_seen = 0;
      for (int i = 0; i < 30; i++) begin
         tick();
         if (gnt_o[2]) gnt_seen++;
      end
      check_val("to_lockout", gnt_seen, 0);
      req_i = 3'b000; tick();
      req_i = 3'b100; t = 0;
      while (gnt_o == '0 && t < 20) begin tick(); t++; end
      check_val("to_regrant", gnt_o, 3'b100);
      req_i = '0;
      wait_idle("to_drain");
`endif

      // Randomised requests and per-requester SPI traffic.
      for (int c = 0; c < 2000; c++) begin
         for (int b = 0; b < N; b++) begin
            if ($urandom_range(7) == 0) req_i[b] = ~req_i[b];
         end
         sclk_i     = N'($urandom);
         copi_i     = N'($urandom);
         spi_cipo_i = 1'($urandom);
         tick();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/spi_bus_arbiter.md
Name: spi_bus_arbiter

Overview:
- Shares one physical SPI pin group between NumReq SPI host requesters. Target: the R-Pi SPI1 header bus (SCLK/COPI/CIPO plus three chip selects).
- Each requester owns a fixed chip select, index k drives spi_cs_no[k].
- Grants are round-robin. The block sequences chip-select setup, hold and inter-transaction gap timing, and muxes SCLK/COPI to the current owner.
- Sits in sonata_system between the SPI hosts and the pin-mux outputs to the padring.

Parameters:
- NumReq, 3, number of requesters / chip selects (2..8).
- CsSetupCycles, 2, cycles CS is low before grant (>=1).
- CsHoldCycles, 2, cycles CS stays low after release (>=1).
- GapCycles, 1, cycles all CS high before next selection (>=1).
- Cpol, 1'b0, SCLK idle level driven when no owner.
- TimeoutCycles, 4096, maximum ownership cycles (used only with the optional feature).

Ports:
- clk_sys_i  in  1  system clock
- rst_sys_ni  in  1  asynchronous active-low reset
- req_i  in  NumReq  request / hold ownership, level
- gnt_o  out  NumReq  one-hot grant
- sclk_i  in  NumReq  per-requester SCLK
- copi_i  in  NumReq  per-requester COPI
- cipo_o  out  NumReq  CIPO returned to requesters
- spi_sclk_o  out  1  bus SCLK
- spi_copi_o  out  1  bus COPI
- spi_copi_en_o  out  1  COPI output enable
- spi_cs_no  out  NumReq  active-low chip selects
- spi_cipo_i  in  1  bus CIPO
- busy_o  out  1  state != IDLE
- owner_o  out  $clog2(NumReq)  selected requester index (valid while busy_o)
- timeout_o  out  1  one-cycle pulse on forced revoke (tied 0 without the optional feature)

Behaviour:
- Reset values: state IDLE; gnt_o=0; spi_cs_no=all 1; owner_o=0; busy_o=0; timeout_o=0; last-owner pointer=NumReq-1 (requester 0 wins first); counter=0.
- States: IDLE, SETUP, OWN, HOLD, GAP. Registered state, gnt_o and spi_cs_no.
- IDLE:
  - If any req_i is set, pick the first set bit searching upward from last+1, wrapping modulo NumReq.
  - Latch owner, set last=owner, go to SETUP.
  - spi_cs_no[owner] goes low the next cycle.
- SETUP:
  - Counter runs CsSetupCycles cycles, then OWN.
  - If req_i[owner] drops during SETUP, go to HOLD; gnt_o is never asserted.
- OWN:
  - gnt_o[owner]=1.
  - Combinational pass-through: spi_sclk_o=sclk_i[owner], spi_copi_o=copi_i[owner], spi_copi_en_o=1.
  - When req_i[owner]=0 is sampled, go to HOLD; gnt_o drops the next cycle.
- HOLD: CS stays low for CsHoldCycles cycles, then all CS go high and the block enters GAP.
- GAP: GapCycles cycles, then IDLE.
- Latency: req_i seen at edge k → CS low from k+1 → gnt_o high from k+1+CsSetupCycles.
- Outside OWN: spi_sclk_o=Cpol, spi_copi_o=0, spi_copi_en_o=0.
- CIPO routing: cipo_o[i] = spi_cipo_i & gnt_o[i]; all others 0.
- Exclusivity: at most one CS low and at most one gnt_o bit at any time.
- Requests from non-owners while busy are ignored (no queuing). They are re-evaluated in IDLE.
- Simultaneous requests resolve strictly round-robin. A single persistent requester is re-granted after each GAP.
- Counter width is $clog2(max of the parameters)+1. The counter clears on every state entry.
- Reset asserted mid-transaction: immediate asynchronous return to reset values. CS deasserts without honouring hold time.

Optional Feature:
- Macro: SPI_BUS_ARBITER_TIMEOUT_EN.
- Defined:
  - A watchdog counts cycles in OWN.
  - At TimeoutCycles consecutive OWN cycles, the block forces HOLD, drops gnt_o and pulses timeout_o for 1 cycle.
  - The revoked requester is not re-granted until it deasserts req_i for at least one cycle (per-requester lockout bit, cleared when req_i is low).
- Undefined: no watchdog, no lockout logic, timeout_o tied 0, TimeoutCycles unused.

Test Plan:
- Reset then req_i=3'b001 held: spi_cs_no=3'b110 at cycle 1, gnt_o=3'b001 at cycle 3. Drive sclk_i[0]=1 → spi_sclk_o=1 the same cycle; spi_cipo_i=1 → cipo_o=3'b001.
- Release: drop req_i[0] in OWN → gnt_o=0 next cycle, CS low 2 more cycles, then 3'b111 for 1 GAP cycle, busy_o=0 after.
- Round-robin: req_i=3'b111 held for 3 complete transactions → owner sequence 0,1,2, then 0. No two spi_cs_no bits are ever low together.
- Abort in SETUP: req_i[1] pulses for 1 cycle → CS1 low for 1+2 cycles, gnt_o never set, block returns to IDLE.
- Reset mid-OWN: assert rst_sys_ni=0 asynchronously → spi_cs_no=3'b111 and gnt_o=0 immediately; spi_sclk_o=Cpol.
- With SPI_BUS_ARBITER_TIMEOUT_EN and TimeoutCycles=16: hold req_i[2] → timeout_o pulses after 16 OWN cycles, grant revoked. Requester 2 is not re-granted until req_i[2] goes low then high. A pending req_i[0] is granted meanwhile.
